// File: rtl/uart_cmd_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_cmd_ctrl_if
// Bundles the byte-level handshake between the command/report controller and
// the uart_rx / uart_tx cores.
//   uart_rx_data   received byte, valid while uart_rx_done is high
//   uart_rx_done   one-cycle strobe per received byte
//   uart_tx_busy   transmitter busy, high from the cycle after an accepted enable
//   uart_tx_data   byte to transmit, held stable while uart_tx_enable is high
//   uart_tx_enable one-cycle start strobe for the transmitter
// The master modport is the controller's view; the slave modport is the view
// of the UART cores (or a bench standing in for them).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface uart_cmd_ctrl_if;
    logic [7:0] uart_rx_data;
    logic       uart_rx_done;
    logic       uart_tx_busy;
    logic [7:0] uart_tx_data;
    logic       uart_tx_enable;

    modport master (
        input  uart_rx_data,
        input  uart_rx_done,
        input  uart_tx_busy,
        output uart_tx_data,
        output uart_tx_enable
    );

    modport slave (
        output uart_rx_data,
        output uart_rx_done,
        output uart_tx_busy,
        input  uart_tx_data,
        input  uart_tx_enable
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// uart_cmd_ctrl
// Decodes received command bytes into set/clear/toggle operations on an LED
// bank and sends an uptime report frame (0xA5, seconds hi, seconds lo, led)
// over the UART transmitter, either periodically or on request.
//
// Parameters
//   CLK_FREQ    clock frequency in Hz, one seconds tick every CLK_FREQ cycles
//   LED_NUM     number of LED outputs, 1..32
//   REPORT_SEC  seconds between periodic reports, 1..65535
//
// Ports
//   clk_50m_i   system clock
//   reset_n_i   asynchronous reset, active low
//   bus         UART handshake (uart_cmd_ctrl_if.master)
//   led_o       LED state register
//   pps_o       one-cycle pulse on each seconds increment
//
// Build option
//   REPORT_CHECKSUM_EN  when defined, a fifth frame byte carries the XOR of
//                       bytes 0..3; when undefined the frame is four bytes.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_cmd_ctrl #(
    parameter logic [31:0] CLK_FREQ   = 32'd50_000_000,
    parameter int          LED_NUM    = 6,
    parameter int          REPORT_SEC = 1
) (
    input  logic               clk_50m_i,
    input  logic               reset_n_i,
    uart_cmd_ctrl_if.master    bus,
    output logic [LED_NUM-1:0] led_o,
    output logic               pps_o
);

`ifdef REPORT_CHECKSUM_EN
    localparam int FRAME_LEN = 5;
`else
    localparam int FRAME_LEN = 4;
`endif

    typedef enum logic [1:0] {IDLE, SEND, GAP, WAIT} state_t;

    logic [31:0]        prescale_q, prescale_d;
    logic [15:0]        seconds_q, seconds_d;
    logic [15:0]        period_q, period_d;
    logic               pps_q, pps_d;
    logic [LED_NUM-1:0] led_q, led_d;
    logic [LED_NUM-1:0] idxMask;
    logic               periodicReq;
    logic               cmdReq;
    logic               reportReq;
    logic [7:0]         ledByte;
    logic [7:0]         frameByte;
    logic               lastByte;

    state_t             state_q;
    logic [2:0]         byteIdx_q;
    logic               pending_q;
    logic [7:0]         txData_q;
    logic               txEnable_q;
    logic [15:0]        snapSec_q;
    logic [7:0]         snapLed_q;

    // Timebase: the prescaler wraps at CLK_FREQ-1 and produces the seconds
    // tick. pps is registered, so seconds already holds the new value in the
    // cycle pps is high; the period counter counts those pulses and flags a
    // periodic report on every REPORT_SEC-th one.
    always_comb begin
        prescale_d = prescale_q + 32'd1;
        seconds_d  = seconds_q;
        pps_d      = 1'b0;
        period_d   = period_q;
        if (prescale_q == CLK_FREQ - 32'd1) begin
            prescale_d = '0;
            seconds_d  = seconds_q + 16'd1;
            pps_d      = 1'b1;
        end
        if (pps_q) begin
            period_d = (period_q == 16'(REPORT_SEC - 1)) ? 16'd0 : period_q + 16'd1;
        end
    end

    assign periodicReq = pps_q && (period_q == 16'(REPORT_SEC - 1));

    // Command decode: the low six bits select one LED through a one-hot mask.
    // An index at or beyond LED_NUM matches no mask bit, so toggle/set/clear
    // of a non-existent LED falls out as a no-op without a separate check.
    always_comb begin
        idxMask = '0;
        for (int i = 0; i < LED_NUM; i++) begin
            idxMask[i] = (bus.uart_rx_data[5:0] == 6'(i));
        end
        led_d  = led_q;
        cmdReq = 1'b0;
        if (bus.uart_rx_done) begin
            case (bus.uart_rx_data[7:6])
                2'b00: led_d = led_q ^ idxMask;
                2'b01: led_d = led_q | idxMask;
                2'b10: led_d = led_q & ~idxMask;
                default: begin
                    case (bus.uart_rx_data)
                        8'hFF:   led_d  = '0;
                        8'hFE:   led_d  = '1;
                        8'hFD:   cmdReq = 1'b1;
                        default: led_d  = led_q;
                    endcase
                end
            endcase
        end
    end

    // A command request and a periodic request in the same cycle collapse
    // into a single report request.
    assign reportReq = periodicReq | cmdReq;

    // Timebase and LED register bank.
    always_ff @(posedge clk_50m_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            prescale_q <= '0;
            seconds_q  <= '0;
            period_q   <= '0;
            pps_q      <= 1'b0;
            led_q      <= '0;
        end else begin
            prescale_q <= prescale_d;
            seconds_q  <= seconds_d;
            period_q   <= period_d;
            pps_q      <= pps_d;
            led_q      <= led_d;
        end
    end

    // The report carries the low eight LEDs, zero-extended for small banks.
    if (LED_NUM >= 8) begin : g_ledWide
        assign ledByte = led_q[7:0];
    end else begin : g_ledNarrow
        assign ledByte = {{(8 - LED_NUM){1'b0}}, led_q};
    end

    // Frame byte selection from the snapshot taken when the frame started,
    // so LED changes and seconds ticks during the frame do not leak in.
    always_comb begin
        frameByte = 8'h00;
        case (byteIdx_q)
            3'd0: frameByte = 8'hA5;
            3'd1: frameByte = snapSec_q[15:8];
            3'd2: frameByte = snapSec_q[7:0];
            3'd3: frameByte = snapLed_q;
`ifdef REPORT_CHECKSUM_EN
            3'd4: frameByte = 8'hA5 ^ snapSec_q[15:8] ^ snapSec_q[7:0] ^ snapLed_q;
`endif
            default: frameByte = 8'h00;
        endcase
    end

    assign lastByte = (byteIdx_q == 3'(FRAME_LEN - 1));

    // Transmit FSM. A request arriving outside IDLE is remembered in a
    // one-deep pending flag; any number of further requests merge into it.
    // GAP gives the transmitter one cycle to raise busy before WAIT looks
    // at it, so a byte is never mistaken for finished before it started.
    always_ff @(posedge clk_50m_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            byteIdx_q  <= '0;
            pending_q  <= 1'b0;
            txData_q   <= '0;
            txEnable_q <= 1'b0;
            snapSec_q  <= '0;
            snapLed_q  <= '0;
        end else begin
            txEnable_q <= 1'b0;
            if (state_q != IDLE && reportReq) begin
                pending_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (reportReq || pending_q) begin
                        snapSec_q <= seconds_q;
                        snapLed_q <= ledByte;
                        pending_q <= 1'b0;
                        byteIdx_q <= '0;
                        state_q   <= SEND;
                    end
                end
                SEND: begin
                    if (!bus.uart_tx_busy) begin
                        txData_q   <= frameByte;
                        txEnable_q <= 1'b1;
                        state_q    <= GAP;
                    end
                end
                GAP: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (!bus.uart_tx_busy) begin
                        if (lastByte) begin
                            state_q <= IDLE;
                        end else begin
                            byteIdx_q <= byteIdx_q + 3'd1;
                            state_q   <= SEND;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.uart_tx_data   = txData_q;
    assign bus.uart_tx_enable = txEnable_q;
    assign led_o              = led_q;
    assign pps_o              = pps_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_ctrl
// Three controller instances share one clock:
//   A  slow timebase (no seconds ticks), LED commands, request latency,
//      pending/merge behaviour and reset in the middle of a frame
//   B  CLK_FREQ=10, REPORT_SEC=2, ten-cycle busy: first periodic frame
//   C  CLK_FREQ=10, periodic reports effectively off: frame at seconds=0x0102
// Expected frame bytes are queued when a request is driven and popped by a
// per-instance monitor on every transmit enable.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_cmd_ctrl;

`ifdef REPORT_CHECKSUM_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif

    typedef struct {
        logic [7:0] cmd;
        logic [5:0] led;
    } vec_t;

    logic clk    = 1'b0;
    logic rstA_n = 1'b0;
    logic rstBC_n = 1'b0;

    logic [5:0] ledA, ledB, ledC;
    logic       ppsA, ppsB, ppsC;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int bytesA = 0, bytesB = 0, bytesC = 0;
    int busyCntA = 0, busyCntB = 0, busyCntC = 0;
    int ppsCountC = 0;
    int lastPpsC  = 0;

    logic [7:0] expA[$];
    logic [7:0] expB[$];
    logic [7:0] expC[$];

    vec_t vecs[14];

    uart_cmd_ctrl_if ifA ();
    uart_cmd_ctrl_if ifB ();
    uart_cmd_ctrl_if ifC ();

    uart_cmd_ctrl #(.CLK_FREQ(32'd50_000_000), .LED_NUM(6), .REPORT_SEC(1)) dutA (
        .clk_50m_i (clk),
        .reset_n_i (rstA_n),
        .bus       (ifA.master),
        .led_o     (ledA),
        .pps_o     (ppsA)
    );

    uart_cmd_ctrl #(.CLK_FREQ(32'd10), .LED_NUM(6), .REPORT_SEC(2)) dutB (
        .clk_50m_i (clk),
        .reset_n_i (rstBC_n),
        .bus       (ifB.master),
        .led_o     (ledB),
        .pps_o     (ppsB)
    );

    uart_cmd_ctrl #(.CLK_FREQ(32'd10), .LED_NUM(6), .REPORT_SEC(65535)) dutC (
        .clk_50m_i (clk),
        .reset_n_i (rstBC_n),
        .bus       (ifC.master),
        .led_o     (ledC),
        .pps_o     (ppsC)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter stand-ins: busy rises the cycle after an accepted enable
    // and stays high for a fixed number of cycles.
    always @(posedge clk or negedge rstA_n) begin
        if (!rstA_n) busyCntA <= 0;
        else if (ifA.uart_tx_enable && busyCntA == 0) busyCntA <= 4;
        else if (busyCntA != 0) busyCntA <= busyCntA - 1;
    end

    always @(posedge clk or negedge rstBC_n) begin
        if (!rstBC_n) begin
            busyCntB <= 0;
            busyCntC <= 0;
        end else begin
            if (ifB.uart_tx_enable && busyCntB == 0) busyCntB <= 10;
            else if (busyCntB != 0) busyCntB <= busyCntB - 1;
            if (ifC.uart_tx_enable && busyCntC == 0) busyCntC <= 4;
            else if (busyCntC != 0) busyCntC <= busyCntC - 1;
        end
    end

    assign ifA.uart_tx_busy = (busyCntA != 0);
    assign ifB.uart_tx_busy = (busyCntB != 0);
    assign ifC.uart_tx_busy = (busyCntC != 0);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic unexpectedByte(input string name, input logic [7:0] actual);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=%02h required=no byte", name, actual);
    endtask

    // Monitors: every enable is checked against busy and against the queue.
    always @(negedge clk) begin
        if (rstA_n && ifA.uart_tx_enable) begin
            bytesA++;
            checkOutput("A_busyAtEnable", 32'(ifA.uart_tx_busy), 32'd0);
            if (expA.size() > 0) checkOutput("A_txByte", 32'(ifA.uart_tx_data), 32'(expA.pop_front()));
            else unexpectedByte("A_unexpectedByte", ifA.uart_tx_data);
        end
        if (rstBC_n && ifB.uart_tx_enable) begin
            bytesB++;
            checkOutput("B_busyAtEnable", 32'(ifB.uart_tx_busy), 32'd0);
            if (expB.size() > 0) checkOutput("B_txByte", 32'(ifB.uart_tx_data), 32'(expB.pop_front()));
        end
        if (rstBC_n && ifC.uart_tx_enable) begin
            bytesC++;
            checkOutput("C_busyAtEnable", 32'(ifC.uart_tx_busy), 32'd0);
            if (expC.size() > 0) checkOutput("C_txByte", 32'(ifC.uart_tx_data), 32'(expC.pop_front()));
            else unexpectedByte("C_unexpectedByte", ifC.uart_tx_data);
        end
        if (rstBC_n && ppsC) begin
            ppsCountC++;
            if (ppsCountC >= 2 && ppsCountC <= 3) checkOutput("C_ppsPeriod", 32'(cyc - lastPpsC), 32'd10);
            lastPpsC = cyc;
        end
    end

    // Drives one received byte for one clock on the chosen instance
    // (0 = A, 1 = B, 2 = C).
    task automatic applyStimulus(input int which, input logic [7:0] cmd);
        @(posedge clk);
        #1;
        case (which)
            0: begin ifA.uart_rx_data = cmd; ifA.uart_rx_done = 1'b1; end
            1: begin ifB.uart_rx_data = cmd; ifB.uart_rx_done = 1'b1; end
            default: begin ifC.uart_rx_data = cmd; ifC.uart_rx_done = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        ifA.uart_rx_done = 1'b0;
        ifB.uart_rx_done = 1'b0;
        ifC.uart_rx_done = 1'b0;
    endtask

    task automatic pushFrame(input int which, input logic [15:0] sec, input logic [7:0] ledByte);
        logic [7:0] f[5];
        f[0] = 8'hA5;
        f[1] = sec[15:8];
        f[2] = sec[7:0];
        f[3] = ledByte;
        f[4] = 8'hA5 ^ sec[15:8] ^ sec[7:0] ^ ledByte;
        for (int i = 0; i < FL; i++) begin
            case (which)
                0: expA.push_back(f[i]);
                1: expB.push_back(f[i]);
                default: expC.push_back(f[i]);
            endcase
        end
    endtask

    task automatic waitDrained(input int which, input int budget, input string name);
        int left;
        for (int k = 0; k < budget; k++) begin
            left = (which == 0) ? expA.size() : (which == 1) ? expB.size() : expC.size();
            if (left == 0) break;
            @(posedge clk);
        end
        #1;
        left = (which == 0) ? expA.size() : (which == 1) ? expB.size() : expC.size();
        checkOutput(name, 32'(left), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;

        vecs[0]  = '{cmd: 8'h02, led: 6'b000100};
        vecs[1]  = '{cmd: 8'h02, led: 6'b000000};
        vecs[2]  = '{cmd: 8'h43, led: 6'b001000};
        vecs[3]  = '{cmd: 8'hFE, led: 6'b111111};
        vecs[4]  = '{cmd: 8'h81, led: 6'b111101};
        vecs[5]  = '{cmd: 8'h06, led: 6'b111101};
        vecs[6]  = '{cmd: 8'h3F, led: 6'b111101};
        vecs[7]  = '{cmd: 8'hC5, led: 6'b111101};
        vecs[8]  = '{cmd: 8'h45, led: 6'b111101};
        vecs[9]  = '{cmd: 8'h00, led: 6'b111100};
        vecs[10] = '{cmd: 8'hFF, led: 6'b000000};
        vecs[11] = '{cmd: 8'h85, led: 6'b000000};
        vecs[12] = '{cmd: 8'h40, led: 6'b000001};
        vecs[13] = '{cmd: 8'h05, led: 6'b100001};

        ifA.uart_rx_data = 8'h00; ifA.uart_rx_done = 1'b0;
        ifB.uart_rx_data = 8'h00; ifB.uart_rx_done = 1'b0;
        ifC.uart_rx_data = 8'h00; ifC.uart_rx_done = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("A_resetLed", 32'(ledA), 32'd0);
        checkOutput("A_resetPps", 32'(ppsA), 32'd0);
        checkOutput("A_resetTxEnable", 32'(ifA.uart_tx_enable), 32'd0);
        checkOutput("A_resetTxData", 32'(ifA.uart_tx_data), 32'd0);
        checkOutput("B_resetLed", 32'(ledB), 32'd0);

        // B's first periodic report comes at seconds=2 with all LEDs off.
        pushFrame(1, 16'h0002, 8'h00);
        @(negedge clk);
        rstA_n  = 1'b1;
        rstBC_n = 1'b1;

        // C: LEDs 0 and 2 on, kept until its report at seconds=0x0102.
        applyStimulus(2, 8'h40);
        applyStimulus(2, 8'h42);
        checkOutput("C_ledSetup", 32'(ledC), 32'h05);

        // A: LED command table, update visible the cycle after rx_done.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(0, vecs[i].cmd);
            checkOutput($sformatf("A_led_vec%0d", i), 32'(ledA), 32'(vecs[i].led));
        end

        // A: request latency, then two more requests and an LED clear while
        // the frame is running; exactly one extra frame, with the new LEDs.
        pushFrame(0, 16'h0000, 8'h21);
        applyStimulus(0, 8'hFD);
        checkOutput("A_latencyN1", 32'(ifA.uart_tx_enable), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("A_latencyN2", 32'(ifA.uart_tx_enable), 32'd1);
        pushFrame(0, 16'h0000, 8'h00);
        applyStimulus(0, 8'hFD);
        applyStimulus(0, 8'hFF);
        checkOutput("A_ledClearMidFrame", 32'(ledA), 32'd0);
        applyStimulus(0, 8'hFD);
        waitDrained(0, 400, "A_mergedFramesDrained");
        repeat (100) @(posedge clk);
        #1;
        checkOutput("A_twoFramesOnly", 32'(bytesA), 32'(2 * FL));

        // A: reset right after the first byte of a frame is enabled.
        applyStimulus(0, 8'h40);
        base = bytesA;
        expA.push_back(8'hA5);
        applyStimulus(0, 8'hFD);
        for (int k = 0; k < 100 && bytesA < base + 1; k++) @(posedge clk);
        #1;
        checkOutput("A_firstByteSeen", 32'(bytesA), 32'(base + 1));
        rstA_n = 1'b0;
        #1;
        checkOutput("A_midResetTxEnable", 32'(ifA.uart_tx_enable), 32'd0);
        checkOutput("A_midResetTxData", 32'(ifA.uart_tx_data), 32'd0);
        checkOutput("A_midResetLed", 32'(ledA), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rstA_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        checkOutput("A_noResumeAfterReset", 32'(bytesA), 32'(base + 1));
        pushFrame(0, 16'h0000, 8'h00);
        applyStimulus(0, 8'hFD);
        waitDrained(0, 400, "A_frameAfterReset");

        // B: first periodic frame.
        waitDrained(1, 600, "B_firstPeriodicFrame");

        // C: request a report at seconds=0x0102 with LEDs 0x05; seconds keep
        // ticking during the frame, the snapshot must not.
        for (int k = 0; k < 4000 && ppsCountC < 258; k++) @(posedge clk);
        #1;
        checkOutput("C_ppsCountReached", 32'(ppsCountC), 32'd258);
        pushFrame(2, 16'h0102, 8'h05);
        applyStimulus(2, 8'hFD);
        waitDrained(2, 400, "C_secondsFrame");
        repeat (20) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
